// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared size codes, FSM states and constants for the MEM stage.
package mem_access_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, STORE = 2'd2, DONE = 2'd3} state_e;
  localparam logic [1:0] MEM_SEL_BYTE = 2'b00;
  localparam logic [1:0] MEM_SEL_HALF = 2'b01;
  localparam logic [1:0] MEM_SEL_WORD = 2'b10;
  localparam logic RST_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  function automatic logic [2:0] beats(input logic [1:0] sel);
    return sel[1] ? 3'd4 : sel[0] ? 3'd2 : 3'd1;
  endfunction
endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: byte-wide unified RAM bus between the MEM stage and memory.
interface mem_access_if #(parameter int RAM_AW = 17);
  logic [RAM_AW-1:0] ram_a_o;
  logic [7:0] ram_dout_o;
  logic ram_wr_o;
  logic [7:0] ram_din_i;
  modport master(output ram_a_o, ram_dout_o, ram_wr_o, input ram_din_i);
  modport slave(input ram_a_o, ram_dout_o, ram_wr_o, output ram_din_i);
endinterface

// File: rtl/mem_ld_extend.sv
// mem_ld_extend: sign/zero extension of an assembled load value by access size.
module mem_ld_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] asm_i,
  input  logic [1:0]  sel_i,
  input  logic        sign_i,
  output logic [31:0] ext_o
);
  assign ext_o = sel_i == MEM_SEL_BYTE ? {{24{sign_i & asm_i[7]}}, asm_i[7:0]} :
                 sel_i == MEM_SEL_HALF ? {{16{sign_i & asm_i[15]}}, asm_i[15:0]} : asm_i;
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store serialiser onto a byte-wide RAM bus.
// Optional MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses via misalign_o.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RAM_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy_i,
  input  logic              req_valid_i,
  input  logic              is_mem_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_sel_i,
  input  logic              load_sign_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       store_data_i,
  input  logic [31:0]       alu_wdata_i,
  input  logic [4:0]        rd_i,
  input  logic              wreg_i,
  mem_access_if.master      bus,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       wdata_o,
  output logic [4:0]        rd_o,
  output logic              wreg_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,output logic             misalign_o
`endif
);
  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d, n, beat_off;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [1:0] sel_q, sel_d;
  logic sign_q, sign_d, wreg_q, wreg_d, busy;
  logic [31:0] sdata_q, sdata_d, asm_q, asm_d, asm_cap, wdata_q, wdata_d, ext;
  logic [4:0] rd_q, rd_d;
  logic unused_addr;
`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q, mis_d, mis_a;
  assign mis_a = (mem_sel_i == MEM_SEL_HALF && mem_addr_i[0]) || (mem_sel_i[1] && mem_addr_i[1:0] != 2'b00);
  assign misalign_o = mis_q & done_o;
`endif
  // Only the low RAM_AW address bits ever reach the bus, and the wrap is identical there.
  assign unused_addr = ^mem_addr_i[ADDR_W-1:RAM_AW];
  assign n = beats(sel_q);
  always_comb begin
    asm_cap = asm_q;
    if (cnt_q != 3'd0) asm_cap[{cnt_q[1:0] - 2'd1, 3'b000} +: 8] = bus.ram_din_i;
  end
  mem_ld_extend u_ext (.asm_i(asm_cap), .sel_i(sel_q), .sign_i(sign_q), .ext_o(ext));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    sel_d = sel_q;
    sign_d = sign_q;
    sdata_d = sdata_q;
    rd_d = rd_q;
    wreg_d = wreg_q;
    asm_d = asm_q;
    wdata_d = wdata_q;
`ifdef MEM_MISALIGN_TRAP_EN
    mis_d = mis_q;
`endif
    if (rdy_i)
      case (state_q)
        IDLE: if (req_valid_i) begin
          rd_d = rd_i;
          wreg_d = wreg_i & !(is_mem_i & mem_we_i);
          cnt_d = 3'd0;
          asm_d = ZERO_WORD;
          wdata_d = is_mem_i ? ZERO_WORD : alu_wdata_i;
          addr_d = mem_addr_i[RAM_AW-1:0];
          sel_d = mem_sel_i;
          sign_d = load_sign_i;
          sdata_d = store_data_i;
          state_d = !is_mem_i ? DONE : mem_we_i ? STORE : LOAD;
`ifdef MEM_MISALIGN_TRAP_EN
          mis_d = is_mem_i & mis_a;
          if (is_mem_i & mis_a) begin
            state_d = DONE;
            wreg_d = 1'b0;
          end
`endif
        end
        LOAD: begin
          asm_d = asm_cap;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == n) begin
            state_d = DONE;
            wdata_d = ext;
          end
        end
        STORE: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == n - 3'd1) state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (rst == RST_ENABLE) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      sel_q <= '0;
      sign_q <= 1'b0;
      sdata_q <= ZERO_WORD;
      rd_q <= '0;
      wreg_q <= 1'b0;
      asm_q <= ZERO_WORD;
      wdata_q <= ZERO_WORD;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      sel_q <= sel_d;
      sign_q <= sign_d;
      sdata_q <= sdata_d;
      rd_q <= rd_d;
      wreg_q <= wreg_d;
      asm_q <= asm_d;
      wdata_q <= wdata_d;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q <= mis_d;
`endif
    end
  // A frozen load beat re-presents the previous byte address so its data is re-read on resume.
  assign busy = state_q == LOAD || state_q == STORE;
  assign beat_off = (state_q == LOAD && !rdy_i && cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
  assign bus.ram_a_o = busy ? addr_q + RAM_AW'(beat_off) : '0;
  assign bus.ram_dout_o = state_q == STORE ? sdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
  assign bus.ram_wr_o = state_q == STORE && rdy_i;
  assign stall_o = busy || (state_q == IDLE && req_valid_i && is_mem_i);
  assign done_o = state_q == DONE;
  assign wdata_o = wdata_q;
  assign rd_o = rd_q;
  assign wreg_o = wreg_q & done_o;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized + directed bench for mem_access against a transaction-level model.
module tb_mem_access;
  localparam int AW = 17;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, req_valid = 1'b0, is_mem = 1'b0, we = 1'b0, sign = 1'b0, wreg = 1'b0;
  logic [1:0] sel = 2'b00;
  logic [31:0] addr = '0, sdata = '0, alu = '0;
  logic [4:0] rd = '0;
  logic stall, done, wreg_o;
  logic [31:0] wdata;
  logic [4:0] rd_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign;
`endif
  mem_access_if #(.RAM_AW(AW)) bus();
  mem_access #(.ADDR_W(32), .RAM_AW(AW)) dut (
    .clk(clk), .rst(rst), .rdy_i(rdy), .req_valid_i(req_valid), .is_mem_i(is_mem), .mem_we_i(we),
    .mem_sel_i(sel), .load_sign_i(sign), .mem_addr_i(addr), .store_data_i(sdata), .alu_wdata_i(alu),
    .rd_i(rd), .wreg_i(wreg), .bus(bus), .stall_o(stall), .done_o(done), .wdata_o(wdata), .rd_o(rd_o),
    .wreg_o(wreg_o)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_o(misalign)
`endif
  );
  always #5 clk = ~clk;

  logic [7:0] ram [0:2**AW-1];
  logic [7:0] refm [0:2**AW-1];
  always @(posedge clk) begin
    bus.ram_din_i <= ram[bus.ram_a_o];
    if (bus.ram_wr_o) ram[bus.ram_a_o] <= bus.ram_dout_o;
  end

  int checks = 0, errors = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {logic [31:0] wdata; logic [4:0] rd; logic wreg; logic mis;} res_t;
  res_t exp_res[$];
  logic [24:0] exp_wr[$];
  logic [31:0] last_wdata = '0;
  logic last_wreg = 1'b0, last_mis = 1'b0;

  always @(negedge clk) begin
    logic [24:0] w;
    res_t e;
    if (bus.ram_wr_o) begin
      check("wr_needs_rdy", {31'b0, rdy}, 32'd1);
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %h data %h, none expected", bus.ram_a_o, bus.ram_dout_o);
      end else begin
        w = exp_wr.pop_front();
        check("wr_addr", {15'b0, bus.ram_a_o}, {15'b0, w[24:8]});
        check("wr_data", {24'b0, bus.ram_dout_o}, {24'b0, w[7:0]});
      end
    end
    if (done) begin
      if (exp_res.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: wdata %h, none expected", wdata);
      end else begin
        e = exp_res.pop_front();
        check("wdata", wdata, e.wdata);
        check("rd", {27'b0, rd_o}, {27'b0, e.rd});
        check("wreg", {31'b0, wreg_o}, {31'b0, e.wreg});
`ifdef MEM_MISALIGN_TRAP_EN
        check("misalign", {31'b0, misalign}, {31'b0, e.mis});
        last_mis = misalign;
`endif
        last_wdata = wdata;
        last_wreg = wreg_o;
      end
    end
  end

  function automatic logic [31:0] ld_model(input logic [31:0] a, input logic [1:0] s, input logic sg);
    int nb = s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
    logic [31:0] v = 0, t;
    for (int i = 0; i < nb; i++) begin
      t = a + 32'(i);
      v = v | (32'(refm[t[AW-1:0]]) << (8 * i));
    end
    if (sg && nb == 1 && v[7]) v = v | 32'hFFFFFF00;
    if (sg && nb == 2 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  // hold: -2 rdy always high, -1 random rdy, k>=0 rdy low for 3 cycles from wait cycle k
  task automatic tx(input bit m, w, input bit [1:0] s, input bit sg, input bit [31:0] a, d, al,
                    input bit [4:0] r, input bit wr, input int hold);
    int nb = s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
    int lat, cnt = 0, it = 0;
    bit mis = 0;
    logic [31:0] t;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = m && ((s == 2'd1 && a[0]) || (s[1] && a[1:0] != 2'b00));
`endif
    if (!m) begin
      exp_res.push_back('{al, r, wr, 1'b0});
      lat = 0;
    end else if (mis) begin
      exp_res.push_back('{32'h0, r, 1'b0, 1'b1});
      lat = 0;
    end else if (w) begin
      for (int i = 0; i < nb; i++) begin
        t = a + 32'(i);
        exp_wr.push_back({t[AW-1:0], d[8*i +: 8]});
        refm[t[AW-1:0]] = d[8*i +: 8];
      end
      exp_res.push_back('{32'h0, r, 1'b0, 1'b0});
      lat = nb;
    end else begin
      exp_res.push_back('{ld_model(a, s, sg), r, wr, 1'b0});
      lat = nb + 1;
    end
    req_valid = 1; is_mem = m; we = w; sel = s; sign = sg; addr = a; sdata = d; alu = al; rd = r; wreg = wr; rdy = 1;
    #1 check("stall_req", {31'b0, stall}, {31'b0, m});
    @(posedge clk); #2;
    req_valid = 0;
    is_mem = 1'($urandom); we = 1'($urandom); sel = 2'($urandom); addr = $urandom; sdata = $urandom;
    alu = $urandom; rd = 5'($urandom); wreg = 1'($urandom); sign = 1'($urandom);
    while (!done && it < 60) begin
      check("stall_busy", {31'b0, stall}, 32'd1);
      rdy = hold == -1 ? ($urandom_range(3) != 0) : hold >= 0 ? !(it >= hold && it < hold + 3) : 1'b1;
      if (rdy) cnt++;
      it++;
      @(posedge clk); #2;
    end
    check("done_seen", {31'b0, done}, 32'd1);
    check("latency", cnt, lat);
    check("stall_done", {31'b0, stall}, 32'd0);
    rdy = 1;
    @(posedge clk); #2;
    check("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      ram[i] = 8'($urandom);
      refm[i] = ram[i];
    end
    ram[17'h200] = 8'h11; ram[17'h201] = 8'h22; ram[17'h202] = 8'h33; ram[17'h203] = 8'h44;
    ram[17'h204] = 8'h55; ram[17'h205] = 8'h66; ram[17'h1FFFE] = 8'h34; ram[17'h1FFFF] = 8'h80;
    for (int i = 0; i < 4; i++) ram[17'h300 + i] = 8'h00;
    for (int i = 0; i < 2**AW; i++) refm[i] = ram[i];
    repeat (3) @(posedge clk);
    #2;
    check("rst_ram_a", {15'b0, bus.ram_a_o}, 32'd0);
    check("rst_ram_dout", {24'b0, bus.ram_dout_o}, 32'd0);
    check("rst_ram_wr", {31'b0, bus.ram_wr_o}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_rd", {27'b0, rd_o}, 32'd0);
    check("rst_wreg", {31'b0, wreg_o}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    rst = 0;
    @(posedge clk); #2;
    tx(1, 1, 2'd0, 0, 32'h100, 32'h000000A5, 0, 5'd1, 1, -2);
    tx(1, 0, 2'd0, 1, 32'h100, 0, 0, 5'd2, 1, -2);
    check("lb_literal", last_wdata, 32'hFFFFFFA5);
    tx(1, 0, 2'd0, 0, 32'h100, 0, 0, 5'd3, 1, -2);
    check("lbu_literal", last_wdata, 32'h000000A5);
    tx(1, 0, 2'd2, 0, 32'h200, 0, 0, 5'd4, 1, -2);
    check("lw_literal", last_wdata, 32'h44332211);
    tx(1, 0, 2'd1, 1, 32'h1FFFE, 0, 0, 5'd5, 1, -2);
    check("lh_literal", last_wdata, 32'hFFFF8034);
    tx(0, 0, 2'd0, 0, 0, 0, 32'hDEADBEEF, 5'd6, 1, -2);
    check("pass_literal", last_wdata, 32'hDEADBEEF);
    check("pass_wreg_literal", {31'b0, last_wreg}, 32'd1);
    tx(1, 1, 2'd2, 0, 32'h400, 32'h87654321, 0, 5'd7, 0, 1);
    tx(1, 0, 2'd2, 0, 32'h400, 0, 0, 5'd8, 1, 2);
    check("sw_hold_literal", last_wdata, 32'h87654321);
    // reset lands while the second beat of a word store is strobed
    for (int i = 0; i < 2; i++) begin
      exp_wr.push_back({17'h300 + 17'(i), i == 0 ? 8'h0D : 8'hF0});
      refm[17'h300 + i] = i == 0 ? 8'h0D : 8'hF0;
    end
    req_valid = 1; is_mem = 1; we = 1; sel = 2'd2; addr = 32'h300; sdata = 32'hCAFEF00D; rdy = 1;
    @(posedge clk); #2;
    req_valid = 0;
    @(posedge clk); #2;
    rst = 1;
    @(posedge clk); #2;
    check("rst_mid_wr", {31'b0, bus.ram_wr_o}, 32'd0);
    check("rst_mid_stall", {31'b0, stall}, 32'd0);
    check("rst_mid_done", {31'b0, done}, 32'd0);
    rst = 0;
    @(posedge clk); #2;
    tx(1, 0, 2'd2, 0, 32'h300, 0, 0, 5'd9, 1, -2);
    check("after_rst_literal", last_wdata, 32'h0000F00D);
    tx(1, 0, 2'd2, 0, 32'h202, 0, 0, 5'd10, 1, -2);
`ifdef MEM_MISALIGN_TRAP_EN
    check("misalign_literal", {31'b0, last_mis}, 32'd1);
    check("misalign_wreg_literal", {31'b0, last_wreg}, 32'd0);
    check("misalign_wdata_literal", last_wdata, 32'd0);
`else
    check("misaligned_lw_literal", last_wdata, 32'h66554433);
`endif
    tx(1, 0, 2'd2, 1, 32'hFFFFFFFF, 0, 0, 5'd11, 1, -1);
    for (int k = 0; k < 200; k++) begin
      logic [31:0] a = $urandom;
      if ($urandom_range(1) == 1) a[1:0] = 2'b00;
      tx($urandom_range(4) != 0, 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, $urandom,
         5'($urandom), 1'($urandom), -1);
    end
    check("wr_queue_empty", exp_wr.size(), 32'd0);
    check("res_queue_empty", exp_res.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
